// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants, FSM state encoding and address helper for the MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;

    localparam int SRAM_ADDR_LEN = 18;
    localparam int SRAM_DATA_LEN = 16;
    localparam int DATA_MEM_BASE = 1024;
    localparam int WORD_ADDR_LEN = SRAM_ADDR_LEN - 1;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_LOW  = 2'd1,
        MS_HIGH = 2'd2,
        MS_DONE = 2'd3
    } ms_state_e;

    // Half-word address of one 16-bit half of a 32-bit word.
    function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(
        input logic [WORD_ADDR_LEN-1:0] word,
        input logic                     hi
    );
        return {word, hi};
    endfunction

endpackage

// File: rtl/mem_sram_ctrl_wait_counter.sv
// Per-access hold counter: counts up from a synchronous clear and flags done once it reaches WAIT_CYCLES.
module mem_sram_ctrl_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    assign done_o = (count_q == 4'(WAIT_CYCLES));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !done_o) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller splitting each 32-bit load/store into two 16-bit SRAM accesses.
// Optional one-entry read cache enabled by defining MEM_RD_CACHE_EN.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_BASE    = DATA_MEM_BASE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [31:0]              alu_res,
    input  logic [31:0]              val_r_m,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic                     freeze,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    output logic                     sram_dq_oe,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_we_n
);

    ms_state_e                state_q;
    logic                     is_store_q;
    logic [WORD_ADDR_LEN-1:0] word_q;
    logic [31:0]              read_data_q;
    logic                     ready_q;
    logic [SRAM_ADDR_LEN-1:0] sram_addr_q;
    logic [SRAM_DATA_LEN-1:0] dq_out_q;
    logic                     dq_oe_q;
    logic                     we_n_q;

    logic                     req;
    logic [18:0]              req_diff;
    logic [WORD_ADDR_LEN-1:0] req_word;
    logic                     unused_addr_bits;
    logic                     cnt_en;
    logic                     cnt_clr;
    logic                     cnt_done;
    logic                     cache_hit;
    logic                     go_done;
    logic [31:0]              hit_data;

    assign req = mem_r_en | mem_w_en;

    // Only the low 19 bits of the modulo-2^32 difference reach the 17-bit word address.
    assign req_diff         = alu_res[18:0] - 19'(MEM_BASE);
    assign req_word         = req_diff[18:2];
    assign unused_addr_bits = ^{alu_res[31:19], req_diff[1:0]};

    assign freeze = req & (state_q != MS_DONE);

    assign read_data   = read_data_q;
    assign ready       = ready_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

    assign cnt_en  = (state_q == MS_LOW) || (state_q == MS_HIGH);
    assign cnt_clr = !cnt_en || cnt_done;

    mem_sram_ctrl_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .done_o(cnt_done)
    );

`ifdef MEM_RD_CACHE_EN
    logic                     cache_valid_q;
    logic [WORD_ADDR_LEN-1:0] cache_tag_q;
    logic [31:0]              cache_data_q;

    assign cache_hit = cache_valid_q && (cache_tag_q == req_word);
    assign hit_data  = cache_data_q;

    // The tag is the SRAM word address, so aliased byte addresses share one entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
        end else begin
            if (state_q == MS_IDLE && req && mem_w_en && cache_tag_q == req_word) begin
                cache_valid_q <= 1'b0;
            end else if (state_q == MS_HIGH && cnt_done && !is_store_q) begin
                cache_valid_q <= 1'b1;
                cache_tag_q   <= word_q;
                cache_data_q  <= {sram_dq_in, read_data_q[15:0]};
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    assign go_done = mem_r_en & ~mem_w_en & cache_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= MS_IDLE;
            is_store_q  <= 1'b0;
            word_q      <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (req) begin
                        is_store_q <= mem_w_en;
                        word_q     <= req_word;
                        if (go_done) begin
                            state_q     <= MS_DONE;
                            ready_q     <= 1'b1;
                            read_data_q <= hit_data;
                        end else begin
                            state_q     <= MS_LOW;
                            sram_addr_q <= half_addr(req_word, 1'b0);
                            dq_oe_q     <= mem_w_en;
                            we_n_q      <= ~mem_w_en;
                            if (mem_w_en) begin
                                dq_out_q <= val_r_m[15:0];
                            end
                        end
                    end
                end
                MS_LOW: begin
                    if (cnt_done) begin
                        state_q     <= MS_HIGH;
                        sram_addr_q <= half_addr(word_q, 1'b1);
                        if (is_store_q) begin
                            dq_out_q <= val_r_m[31:16];
                        end else begin
                            read_data_q[15:0] <= sram_dq_in;
                        end
                    end
                end
                MS_HIGH: begin
                    if (cnt_done) begin
                        state_q <= MS_DONE;
                        ready_q <= 1'b1;
                        dq_oe_q <= 1'b0;
                        we_n_q  <= 1'b1;
                        if (!is_store_q) begin
                            read_data_q[31:16] <= sram_dq_in;
                        end
                    end
                end
                default: begin
                    state_q <= MS_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
